// File: rtl/alu_writeback.sv
// ALU writeback stage: latches one ALU result and writes it into the
// register file as one narrow (low-half) write or two wide writes
// (low half to rd, high half to rd+1). The stage honours a register-file
// stall, pulses wb_done on the final write of each instruction and keeps
// the architectural equality flag.
module alu_writeback #(
    parameter int REG_ADDR_W = 4,
    parameter int RESULT_W   = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [RESULT_W-1:0]     alu_result,
    input  logic                    alu_eq,
    input  logic [REG_ADDR_W-1:0]   rd,
    input  logic                    wide,
    input  logic                    wb_stall,
    output logic                    rf_we,
    output logic [REG_ADDR_W-1:0]   rf_waddr,
    output logic [RESULT_W/2-1:0]   rf_wdata,
    output logic                    eq_flag,
    output logic                    wb_done
);

    localparam int HALF_W = RESULT_W / 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [RESULT_W-1:0]     r_result;
    logic                    r_eq;
    logic [REG_ADDR_W-1:0]   r_rd;
    logic                    r_wide;
    logic                    r_eq_flag;

    logic                    w_final_state;
    logic                    w_write;
    logic                    w_accept;

    // Decode write strobes and handshake from registered state plus stall only.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        w_final_state = 1'b0;
        w_write       = 1'b0;
        rf_waddr      = r_rd;
        rf_wdata      = r_result[HALF_W-1:0];
        case (r_state)
            WR_LO: begin
                w_final_state = !r_wide;
                w_write       = !wb_stall;
            end
            WR_HI: begin
                w_final_state = 1'b1;
                w_write       = !wb_stall;
                rf_waddr      = r_rd + REG_ADDR_W'(1);  // rd+1 wraps at the top of the file
                rf_wdata      = r_result[RESULT_W-1:HALF_W];
            end
            default: begin
                w_final_state = 1'b0;
                w_write       = 1'b0;
            end
        endcase
        rf_we    = w_write;
        wb_done  = w_write && w_final_state;
        in_ready = (r_state == IDLE) || (w_final_state && !wb_stall);
        w_accept = in_valid && in_ready;
        eq_flag  = r_eq_flag;
    end

    // Next-state: an accept always starts a fresh low write; otherwise advance on unstalled writes.
    always_comb begin
        w_next_state = r_state;
        if (w_accept) begin
            w_next_state = WR_LO;
        end else if (r_state == WR_LO && w_write && r_wide) begin
            w_next_state = WR_HI;
        end else if (wb_done) begin
            w_next_state = IDLE;
        end else if (r_state != IDLE && r_state != WR_LO && r_state != WR_HI) begin
            w_next_state = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latch the accepted instruction; reset clears it so an aborted write cannot resurface.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_eq     <= 1'b0;
            r_rd     <= '0;
            r_wide   <= 1'b0;
        end else if (w_accept) begin
            r_result <= alu_result;
            r_eq     <= alu_eq;
            r_rd     <= rd;
            r_wide   <= wide;
        end
    end

    // Architectural equality flag commits with the final write of an instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eq_flag <= 1'b0;
        end else if (wb_done) begin
            r_eq_flag <= r_eq;
        end
    end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter: REG_ADDR_W, default 4, register-file address width (16 registers).
REQ-002 Parameter: RESULT_W, default 32, ALU result width; register data width is RESULT_W/2 (16).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  ALU result valid.
REQ-006 in_ready  output  1  stage can accept a result this cycle.
REQ-007 alu_result  input  RESULT_W  ALU output word (outALU).
REQ-008 alu_eq  input  1  ALU equality flag.
REQ-009 rd  input  REG_ADDR_W  destination register.
REQ-010 wide  input  1  1 = write full 32-bit result to rd and rd+1; 0 = low half only to rd.
REQ-011 wb_stall  input  1  register file busy; holds pending write.
REQ-012 rf_we  output  1  register-file write enable.
REQ-013 rf_waddr  output  REG_ADDR_W  write address.
REQ-014 rf_wdata  output  RESULT_W/2  write data.
REQ-015 eq_flag  output  1  architectural equality flag.
REQ-016 wb_done  output  1  one-cycle pulse on final write of an instruction.

Function
REQ-017 FSM states SHALL be IDLE, WR_LO, WR_HI.
REQ-018 Accept SHALL occur when in_valid && in_ready; accept latches alu_result, alu_eq, rd, wide.
REQ-019 in_ready SHALL be 1 in IDLE, and 1 in the final write state (WR_LO with wide=0, or WR_HI) when wb_stall=0; 0 otherwise.
REQ-020 Accept from any state SHALL move FSM to WR_LO next cycle.
REQ-021 WR_LO with wb_stall=0: rf_we=1, rf_waddr=rd, rf_wdata=result[15:0]; next state WR_HI if wide, else IDLE (or WR_LO on simultaneous accept).
REQ-022 WR_HI with wb_stall=0: rf_we=1, rf_waddr=rd+1 modulo 2^REG_ADDR_W (15 wraps to 0), rf_wdata=result[31:16]; next state IDLE (or WR_LO on simultaneous accept).
REQ-023 wb_stall=1 in WR_LO/WR_HI: rf_we=0, state and latched data held, in_ready=0.
REQ-024 wb_stall SHALL have no effect in IDLE.
REQ-025 rf_we SHALL be 0 in IDLE; rf_waddr/rf_wdata are don't-care when rf_we=0.
REQ-026 Latency: accept at cycle N -> low write at N+1, high write (wide) at N+2, absent stalls.
REQ-027 Throughput: one narrow result per cycle, one wide result per two cycles, back-to-back without bubbles.
REQ-028 wb_done SHALL be 1 exactly in the cycle of the final unstalled write; eq_flag SHALL update to the latched alu_eq in that same cycle's edge (visible next cycle) and hold otherwise.
REQ-029 Inputs presented while in_ready=0 SHALL be ignored; no data loss if upstream holds in_valid.
REQ-030 rf_we, rf_waddr, rf_wdata, wb_done, in_ready SHALL be decoded from registered state only (no combinational path from in_valid to rf_we).

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, eq_flag=0, latched data=0, rf_we=0, wb_done=0, in_ready=1 (after release).
REQ-032 Reset mid-operation SHALL abort the pending instruction; no partial or late write after release.
REQ-033 First accept SHALL be possible in the first clock edge after rst_n deasserts.

Verification
REQ-034 Narrow: accept result=0x0000_1234, rd=3, wide=0, eq=1 -> next cycle rf_we=1, waddr=3, wdata=0x1234, wb_done=1; eq_flag=1 afterwards.
REQ-035 Wide wrap: result=0xABCD_5678, rd=15, wide=1 -> cycle+1 waddr=15 wdata=0x5678; cycle+2 waddr=0 wdata=0xABCD, wb_done only on cycle+2.
REQ-036 Stall: wide accept, wb_stall=1 for 3 cycles in WR_HI -> rf_we=0, in_ready=0 for 3 cycles, then single write of high half, no duplicate low write.
REQ-037 Back-to-back: in_valid held 4 cycles with narrow results rd=1..4 -> four consecutive writes 1,2,3,4, in_ready constantly 1.
REQ-038 Reset mid-op: assert rst_n=0 during WR_LO of wide instruction -> rf_we=0 immediately, eq_flag=0, no write after release until new accept.
